serial_alu_ctrl: RTL and testbench

- Sequences one external 1-bit ALU slice (inputs a, b, Less, CarryIn, Ainvert, Binvert, Operation[1:0]; outputs Result, CarryOut) bit-serially, LSB first, to run full WIDTH-bit ALU operations.
- Owns the operand and result shift registers, the carry flip-flop, SLT sign resolution, and flag generation.
- Sits between the instruction-level ALU control and the shared slice, with a start/busy/done handshake.

---
 rtl/serial_alu_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_serial_alu_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_alu_ctrl.sv
// Bit-serial sequencer for an external 1-bit ALU slice.
// Runs WIDTH-bit AND/OR/ADD/SUB/SLT/NOR LSB first with start/busy/done.
module serial_alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out,
  output logic             err,
  output logic             s_a,
  output logic             s_b,
  output logic             s_less,
  output logic             s_cin,
  output logic             s_ainvert,
  output logic             s_binvert,
  output logic [1:0]       s_operation,
  input  logic             s_result,
  input  logic             s_carryout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SLTFIX,
    DONE
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       op_q;
  logic             carry_q;
  logic             cin_msb_q;
  logic             cout_q;
  logic             sum_msb_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             ovf_q;
  logic             cflag_q;
  logic             err_q;

  logic             is_slt;
  logic             is_arith;
  logic             last;
  logic             op_ok;
  logic [WIDTH-1:0] res_d;

  assign is_slt   = (op_q == 4'b0111);
  assign is_arith = (op_q == 4'b0010) || (op_q == 4'b0110);
  assign last     = (cnt_q == LAST);

  assign busy      = (state_q == RUN) || (state_q == SLTFIX);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign carry_out = cflag_q;
  assign err       = err_q;

  // Legal op codes accepted from the instruction-level control
  always_comb begin
    op_ok = 1'b0;
    unique case (op)
      4'b0000, 4'b0001, 4'b0010,
      4'b0110, 4'b0111, 4'b1100: op_ok = 1'b1;
      default:                   op_ok = 1'b0;
    endcase
  end

  // Result with the current slice bit merged in at position cnt
  always_comb begin
    res_d        = result_q;
    res_d[cnt_q] = s_result;
  end

  // Slice drive: active only in RUN and SLTFIX, otherwise all zero
  always_comb begin
    s_a         = 1'b0;
    s_b         = 1'b0;
    s_less      = 1'b0;
    s_cin       = 1'b0;
    s_ainvert   = 1'b0;
    s_binvert   = 1'b0;
    s_operation = 2'd0;
    unique case (state_q)
      RUN: begin
        s_a         = a_q[cnt_q];
        s_b         = b_q[cnt_q];
        s_cin       = carry_q;
        s_ainvert   = op_q[3];
        s_binvert   = op_q[2];
        s_operation = is_slt ? 2'd2 : op_q[1:0];
      end
      SLTFIX: begin
        s_operation = 2'd3;
        s_less      = sum_msb_q ^ cin_msb_q ^ cout_q;
      end
      default: ;
    endcase
  end

  // Control FSM with operand, result, carry and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      carry_q   <= 1'b0;
      cin_msb_q <= 1'b0;
      cout_q    <= 1'b0;
      sum_msb_q <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      cflag_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            err_q   <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cflag_q <= 1'b0;
            if (op_ok) begin
              a_q     <= a_in;
              b_q     <= b_in;
              op_q    <= op;
              carry_q <= op[2];
              cnt_q   <= '0;
              state_q <= RUN;
            end else begin
              result_q <= '0;
              err_q    <= 1'b1;
              state_q  <= DONE;
            end
          end
        end
        RUN: begin
          result_q <= res_d;
          carry_q  <= s_carryout;
          cnt_q    <= cnt_q + CW'(1);
          if (last) begin
            cin_msb_q <= carry_q;
            cout_q    <= s_carryout;
            sum_msb_q <= s_result;
            if (is_slt) begin
              state_q <= SLTFIX;
            end else begin
              zero_q  <= (res_d == '0);
              ovf_q   <= is_arith & (carry_q ^ s_carryout);
              cflag_q <= is_arith & s_carryout;
              state_q <= DONE;
            end
          end
        end
        SLTFIX: begin
          result_q <= {{(WIDTH-1){1'b0}}, s_result};
          zero_q   <= ~s_result;
          state_q  <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Bench for serial_alu_ctrl with a behavioural 1-bit slice.
// Expected results queued at start, compared on done.
module tb_serial_alu_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         busy, done, zero, overflow, carry_out, err;
  logic [W-1:0] result;
  logic         s_a, s_b, s_less, s_cin, s_ainvert, s_binvert;
  logic [1:0]   s_operation;
  logic         s_result, s_carryout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         v;
    logic         c;
    logic         e;
    int           lat;
    int           nbusy;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
    .result(result), .zero(zero), .overflow(overflow),
    .carry_out(carry_out), .err(err),
    .s_a(s_a), .s_b(s_b), .s_less(s_less), .s_cin(s_cin),
    .s_ainvert(s_ainvert), .s_binvert(s_binvert),
    .s_operation(s_operation),
    .s_result(s_result), .s_carryout(s_carryout)
  );

  // Classic 1-bit ALU slice
  logic sa, sb_;
  always_comb begin
    sa         = s_a ^ s_ainvert;
    sb_        = s_b ^ s_binvert;
    s_carryout = (sa & sb_) | (sa & s_cin) | (sb_ & s_cin);
    case (s_operation)
      2'd0:    s_result = sa & sb_;
      2'd1:    s_result = sa | sb_;
      2'd2:    s_result = sa ^ sb_ ^ s_cin;
      default: s_result = s_less;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] o,
                                 input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t e;
    logic [W:0] s;
    e.res = '0; e.z = 1'b0; e.v = 1'b0; e.c = 1'b0; e.e = 1'b0;
    e.lat = W + 1; e.nbusy = W;
    case (o)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b1100: e.res = ~(a | b);
      4'b0010: begin
        s = {1'b0, a} + {1'b0, b};
        e.res = s[W-1:0];
        e.c = s[W];
        e.v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
      end
      4'b0110: begin
        s = {1'b0, a} + {1'b0, ~b} + 1;
        e.res = s[W-1:0];
        e.c = s[W];
        e.v = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
      end
      4'b0111: begin
        e.res = ($signed(a) < $signed(b)) ? 1 : 0;
        e.lat = W + 2;
        e.nbusy = W + 1;
      end
      default: begin
        e.e = 1'b1;
        e.lat = 1;
        e.nbusy = 0;
      end
    endcase
    if (!e.e) e.z = (e.res == '0);
    return e;
  endfunction

  task automatic run(input logic [3:0] o, input logic [W-1:0] a,
                     input logic [W-1:0] b, input bit poke);
    exp_t e;
    bit   got;
    int   lat;
    int   nb;
    logic [W-1:0] held;
    sb.push_back(model(o, a, b));
    @(negedge clk);
    op = o; a_in = a; b_in = b; start = 1'b1;
    got = 0; lat = 0; nb = 0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        start = 1'b0;
        if (busy) begin
          check("s_operation", s_operation,
                (o == 4'b0111) ? 2'd2 : o[1:0]);
          check("s_ainvert", s_ainvert, o[3]);
          check("s_binvert", s_binvert, o[2]);
        end
      end
      if (poke && k == 3) begin
        start = 1'b1; op = 4'b0001;
        a_in = ~a; b_in = 8'h11;
      end else if (poke && k == 5) begin
        start = 1'b0;
      end
      if (busy) nb++;
      if (done) begin got = 1; lat = k; end
    end
    if (!got) check("done_timeout", 0, 1);
    e = sb.pop_front();
    check("result", result, e.res);
    check("zero", zero, e.z);
    check("overflow", overflow, e.v);
    check("carry_out", carry_out, e.c);
    check("err", err, e.e);
    check("latency", lat, e.lat);
    check("busy_cycles", nb, e.nbusy);
    check("slice_idle", {s_a, s_b, s_less, s_cin, s_ainvert,
                         s_binvert, s_operation}, 0);
    start = 1'b0;
    held = result;
    @(posedge clk); #1;
    check("done_pulse", done, 0);
    check("result_hold", result, e.res);
  endtask

  initial begin
    #12;
    check("rst_outs", {busy, done, result, zero, overflow,
                       carry_out, err}, 0);
    check("rst_slice", {s_a, s_b, s_less, s_cin, s_ainvert,
                        s_binvert, s_operation}, 0);
    @(negedge clk); rst_n = 1'b1;

    run(4'b0010, 8'h7F, 8'h01, 0);
    run(4'b0110, 8'h05, 8'h05, 0);
    run(4'b0110, 8'h80, 8'h01, 0);
    run(4'b0111, 8'hFD, 8'h02, 0);
    run(4'b0111, 8'h02, 8'hFD, 0);
    run(4'b0111, 8'h80, 8'h7F, 0);
    run(4'b0000, 8'hF0, 8'h3C, 0);
    run(4'b0001, 8'hF0, 8'h3C, 0);
    run(4'b1100, 8'hF0, 8'h3C, 0);
    run(4'b0101, 8'hAA, 8'h55, 0);
    run(4'b0010, 8'h12, 8'h34, 1);
    run(4'b0110, 8'h10, 8'h20, 0);
    for (int i = 0; i < 6; i++) begin
      run(4'b0010, 8'($urandom), 8'($urandom), 0);
      run(4'b0111, 8'($urandom), 8'($urandom), 0);
    end

    // async reset mid-operation at cnt=4
    @(negedge clk);
    op = 4'b0010; a_in = 8'h7F; b_in = 8'h01; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_outs", {busy, done, result, zero, overflow,
                           carry_out, err}, 0);
    check("mid_rst_slice", {s_a, s_b, s_less, s_cin, s_ainvert,
                            s_binvert, s_operation}, 0);
    @(negedge clk); rst_n = 1'b1;
    run(4'b0010, 8'h7F, 8'h01, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
